// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin req/gnt/done arbiter with hold timeout; define WAIT_MONITOR_EN for starvation flags
module rr_grant_scheduler #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout,
  output logic [N-1:0]         starve
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid, r_timeout;
  logic [IW-1:0]   r_gnt_id, r_last, w_sel, w_c;
  logic [HW-1:0]   r_hold;
  logic            w_rel_n, w_rel_f;
  always_comb begin
    w_sel = '0;
    w_c   = '0;
    for (int k = N; k >= 1; k--) begin
      w_c = IW'((int'(r_last) + k) % N);
      if (req[w_c]) w_sel = w_c;
    end
  end
  assign w_rel_n = done | ~req[r_gnt_id];
  assign w_rel_f = ~w_rel_n & (r_hold == HW'(HOLD_MAX));
  always_comb
    w_state_nxt = (r_state == IDLE) ? ((|req) ? BUSY : IDLE)
                                    : ((w_rel_n | w_rel_f) ? IDLE : BUSY);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_timeout   <= 1'b0;
      r_hold      <= '0;
      r_last      <= IW'(N - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= 1'b0;
      if (r_state == IDLE) begin
        if (|req) begin
          r_gnt       <= N'(1) << w_sel;
          r_gnt_valid <= 1'b1;
          r_gnt_id    <= w_sel;
          r_hold      <= HW'(1);
        end
      end else if (w_rel_n | w_rel_f) begin
        r_gnt       <= '0;
        r_gnt_valid <= 1'b0;
        r_last      <= r_gnt_id;
        r_timeout   <= w_rel_f;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign timeout   = r_timeout;
`ifdef WAIT_MONITOR_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] r_wait [N];
  logic [N-1:0]  r_starve;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      for (int i = 0; i < N; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i] & ~r_gnt[i]) begin
          if (r_wait[i] != WW'(MAX_WAIT)) r_wait[i] <= r_wait[i] + 1'b1;
          if (r_wait[i] == WW'(MAX_WAIT - 1)) r_starve[i] <= 1'b1;
        end else begin
          r_wait[i] <= '0;
        end
      end
    end
  end
  assign starve = r_starve;
`else
  assign starve = {N{1'b0}} & {N{MAX_WAIT < 1}};
`endif
endmodule
